// File: rtl/linear_layer_batched_mem_pkg.sv
// Shared definitions for the batched linear layer: FSM state encodings and
// saturation bound helpers used by the requantiser.
package linear_layer_batched_mem_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD_ACT  = 3'd1;
  localparam logic [STATE_W-1:0] ST_LOAD_BIAS = 3'd2;
  localparam logic [STATE_W-1:0] ST_MAC       = 3'd3;
  localparam logic [STATE_W-1:0] ST_POST      = 3'd4;
  localparam logic [STATE_W-1:0] ST_WRITE     = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE      = 3'd6;

  // Largest and smallest values representable in a signed field of width w.
  function automatic longint sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/linear_requant.sv
// Combinational requantiser: arithmetic right shift, optional ReLU, then
// saturation of the accumulator down to the signed output width.
module linear_requant
  import linear_layer_batched_mem_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic        [4:0]           shift_i,
  input  logic                        relu_en_i,
  output logic signed [OUT_WIDTH-1:0] res_o
);

  localparam logic signed [ACC_WIDTH-1:0] SatHi = ACC_WIDTH'(sat_hi(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SatLo = ACC_WIDTH'(sat_lo(OUT_WIDTH));

  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [ACC_WIDTH-1:0] clamped;

  // Shifts past the accumulator width naturally collapse to 0 or -1.
  always_comb begin
    shifted = acc_i >>> shift_i;
    clamped = shifted;
    if (relu_en_i && shifted[ACC_WIDTH-1]) begin
      clamped = '0;
    end
    if (clamped > SatHi) begin
      res_o = SatHi[OUT_WIDTH-1:0];
    end else if (clamped < SatLo) begin
      res_o = SatLo[OUT_WIDTH-1:0];
    end else begin
      res_o = clamped[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/linear_layer_batched_mem.sv
// Batched fully-connected layer engine on the shared single-port memory bus:
// caches each activation vector, accumulates bias + W*x, requantises, writes back.
module linear_layer_batched_mem
  import linear_layer_batched_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int W_WIDTH       = 8,
  parameter int ACC_WIDTH     = 32,
  parameter int OUT_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATABUS_WIDTH = 32,
  parameter int N             = 4,
  parameter int M             = 3,
  parameter int BATCH         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic [4:0]               shift,
  input  logic [ADDR_WIDTH-1:0]    activ_base,
  input  logic [ADDR_WIDTH-1:0]    weight_base,
  input  logic [ADDR_WIDTH-1:0]    bias_base,
  input  logic [ADDR_WIDTH-1:0]    output_base,
  output logic                     mem_w,
  output logic                     mem_sel,
  output logic [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  input  logic                     ready,
  output logic                     busy,
  output logic                     out_valid,
  output logic                     done
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int BW = (BATCH > 1) ? $clog2(BATCH) : 1;

  logic [STATE_W-1:0]            state_q, state_d;
  logic [NW-1:0]                 n_q, n_d;
  logic [MW-1:0]                 m_q, m_d;
  logic [BW-1:0]                 b_q, b_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  act_q [N];
  logic signed [DATA_WIDTH-1:0]  act_d [N];
  logic [ADDR_WIDTH-1:0]         activ_base_q, activ_base_d;
  logic [ADDR_WIDTH-1:0]         weight_base_q, weight_base_d;
  logic [ADDR_WIDTH-1:0]         bias_base_q, bias_base_d;
  logic [ADDR_WIDTH-1:0]         output_base_q, output_base_d;
  logic                          relu_q, relu_d;
  logic [4:0]                    shift_q, shift_d;
  logic                          sel_q, sel_d;
  logic                          w_q, w_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [DATABUS_WIDTH-1:0]      wdata_q, wdata_d;
  logic                          out_valid_q, out_valid_d;

  logic [ADDR_WIDTH-1:0]         actAddr, wgtAddr, biasAddr, outAddr;
  logic signed [DATA_WIDTH-1:0]  rdAct;
  logic signed [W_WIDTH-1:0]     rdWgt;
  logic signed [ACC_WIDTH-1:0]   rdBias;
  logic signed [DATA_WIDTH+W_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   prodExt;
  logic signed [OUT_WIDTH-1:0]   reqRes;

  // Addresses wrap modulo 2^ADDR_WIDTH by truncation.
  assign actAddr  = activ_base_q  + ADDR_WIDTH'(int'(b_q) * N + int'(n_q));
  assign wgtAddr  = weight_base_q + ADDR_WIDTH'(int'(m_q) * N + int'(n_q));
  assign biasAddr = bias_base_q   + ADDR_WIDTH'(int'(m_q));
  assign outAddr  = output_base_q + ADDR_WIDTH'(int'(b_q) * M + int'(m_q));

  assign rdAct   = data_bus[DATA_WIDTH-1:0];
  assign rdWgt   = data_bus[W_WIDTH-1:0];
  assign rdBias  = data_bus[ACC_WIDTH-1:0];
  assign prod    = act_q[n_q] * rdWgt;
  assign prodExt = ACC_WIDTH'(prod);

  linear_requant #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_requant (
    .acc_i    (acc_q),
    .shift_i  (shift_q),
    .relu_en_i(relu_q),
    .res_o    (reqRes)
  );

  // Each access state raises sel after one idle cycle and retires on ready;
  // POST doubles as the idle gap before the write access.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    m_d           = m_q;
    b_d           = b_q;
    acc_d         = acc_q;
    act_d         = act_q;
    activ_base_d  = activ_base_q;
    weight_base_d = weight_base_q;
    bias_base_d   = bias_base_q;
    output_base_d = output_base_q;
    relu_d        = relu_q;
    shift_d       = shift_q;
    sel_d         = sel_q;
    w_d           = w_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    out_valid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          activ_base_d  = activ_base;
          weight_base_d = weight_base;
          bias_base_d   = bias_base;
          output_base_d = output_base;
          relu_d        = relu_en;
          shift_d       = shift;
          n_d           = '0;
          m_d           = '0;
          b_d           = '0;
          state_d       = ST_LOAD_ACT;
        end
      end

      ST_LOAD_ACT: begin
        if (!sel_q) begin
          sel_d  = 1'b1;
          w_d    = 1'b0;
          addr_d = actAddr;
        end else if (ready) begin
          sel_d      = 1'b0;
          act_d[n_q] = rdAct;
          if (n_q == NW'(N - 1)) begin
            n_d     = '0;
            m_d     = '0;
            state_d = ST_LOAD_BIAS;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end

      ST_LOAD_BIAS: begin
        if (!sel_q) begin
          sel_d  = 1'b1;
          w_d    = 1'b0;
          addr_d = biasAddr;
        end else if (ready) begin
          sel_d   = 1'b0;
          acc_d   = rdBias;
          n_d     = '0;
          state_d = ST_MAC;
        end
      end

      ST_MAC: begin
        if (!sel_q) begin
          sel_d  = 1'b1;
          w_d    = 1'b0;
          addr_d = wgtAddr;
        end else if (ready) begin
          sel_d = 1'b0;
          acc_d = acc_q + prodExt;
          if (n_q == NW'(N - 1)) begin
            n_d     = '0;
            state_d = ST_POST;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end

      ST_POST: begin
        sel_d   = 1'b1;
        w_d     = 1'b1;
        addr_d  = outAddr;
        wdata_d = DATABUS_WIDTH'(reqRes);
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        if (sel_q && ready) begin
          sel_d       = 1'b0;
          w_d         = 1'b0;
          out_valid_d = 1'b1;
          if (m_q == MW'(M - 1)) begin
            m_d = '0;
            if (b_q == BW'(BATCH - 1)) begin
              state_d = ST_DONE;
            end else begin
              b_d     = b_q + 1'b1;
              state_d = ST_LOAD_ACT;
            end
          end else begin
            m_d     = m_q + 1'b1;
            state_d = ST_LOAD_BIAS;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 1'b0;
        w_d     = 1'b0;
      end
    endcase
  end

  // Reset drops any in-flight access immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      n_q           <= '0;
      m_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      for (int i = 0; i < N; i++) begin
        act_q[i] <= '0;
      end
      activ_base_q  <= '0;
      weight_base_q <= '0;
      bias_base_q   <= '0;
      output_base_q <= '0;
      relu_q        <= 1'b0;
      shift_q       <= '0;
      sel_q         <= 1'b0;
      w_q           <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      m_q           <= m_d;
      b_q           <= b_d;
      acc_q         <= acc_d;
      act_q         <= act_d;
      activ_base_q  <= activ_base_d;
      weight_base_q <= weight_base_d;
      bias_base_q   <= bias_base_d;
      output_base_q <= output_base_d;
      relu_q        <= relu_d;
      shift_q       <= shift_d;
      sel_q         <= sel_d;
      w_q           <= w_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign mem_sel     = sel_q;
  assign mem_w       = w_q;
  assign address_bus = addr_q;
  assign data_bus    = (sel_q && w_q) ? wdata_q : 'z;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_linear_layer_batched_mem.sv
// Scoreboard bench for the batched linear layer: a latency-3 memory model,
// directed jobs with hand-computed results, and bus protocol monitoring.
module tb_linear_layer_batched_mem;

  localparam int LATENCY = 3;
  localparam logic [7:0] ACT_B  = 8'h10;
  localparam logic [7:0] WGT_B  = 8'h40;
  localparam logic [7:0] BIAS_B = 8'h80;
  localparam logic [7:0] OUT_B  = 8'hC0;

  logic        clk = 1'b0;
  logic        rst, start, relu_en;
  logic [4:0]  shift;
  logic [7:0]  activ_base, weight_base, bias_base, output_base;
  logic        mem_w, mem_sel, ready, busy, out_valid, done;
  logic [7:0]  address_bus;
  wire  [31:0] data_bus;
  logic        tbDrive;
  logic [31:0] tbData;

  assign data_bus = tbDrive ? tbData : 'z;

  always #5 clk = ~clk;

  linear_layer_batched_mem dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .relu_en    (relu_en),
    .shift      (shift),
    .activ_base (activ_base),
    .weight_base(weight_base),
    .bias_base  (bias_base),
    .output_base(output_base),
    .mem_w      (mem_w),
    .mem_sel    (mem_sel),
    .address_bus(address_bus),
    .data_bus   (data_bus),
    .ready      (ready),
    .busy       (busy),
    .out_valid  (out_valid),
    .done       (done)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] mem [256];
  wr_t         expQ [$];
  int passCount = 0;
  int checkCount = 0;
  int accessCount = 0, ovCount = 0, doneCount = 0, protoErr = 0;
  int selCnt = 0, lowRun = 0;
  bit spurEn = 1'b0, armed = 1'b0, prevSel = 1'b0, prevComplete = 1'b0, prevWrite = 1'b0;
  logic [7:0] prevAddr = '0;
  logic       prevW = 1'b0;

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Memory model: ready after LATENCY cycles of sel, optional spurious ready while idle
  initial begin
    ready = 1'b0; tbDrive = 1'b0; tbData = '0;
    forever begin
      @(posedge clk); #1;
      ready = 1'b0; tbDrive = 1'b0;
      if (mem_sel) begin
        if (selCnt >= LATENCY - 1) begin
          ready  = 1'b1;
          selCnt = 0;
          if (!mem_w) begin
            tbDrive = 1'b1;
            tbData  = mem[address_bus];
          end
        end else begin
          selCnt++;
        end
      end else begin
        selCnt = 0;
        ready  = spurEn;
      end
    end
  end

  // Monitor: pops the scoreboard on every completed write and watches the bus rules
  always @(negedge clk) begin
    if (rst) begin
      armed = 1'b0; prevSel = 1'b0; prevComplete = 1'b0; prevWrite = 1'b0;
    end else begin
      if (out_valid !== prevWrite) protoErr++;
      if (out_valid) ovCount++;
      if (done) begin
        doneCount++;
        if (busy) protoErr++;
        armed = 1'b0;
      end
      if (!(mem_sel && mem_w) && !tbDrive && data_bus !== 32'hzzzzzzzz) protoErr++;
      if (tbDrive && data_bus !== tbData) protoErr++;
      if (mem_sel && prevSel && !prevComplete && (address_bus !== prevAddr || mem_w !== prevW))
        protoErr++;
      if (mem_sel && !prevSel && armed && lowRun != 1) protoErr++;
      if (!mem_sel) lowRun++;
      prevWrite = 1'b0;
      if (mem_sel && ready) begin
        accessCount++;
        if (mem_w) begin
          prevWrite = 1'b1;
          mem[address_bus] = data_bus;
          if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected write: addr %0h data %0h, expected no write",
                     address_bus, data_bus);
          end else begin
            wr_t e;
            e = expQ.pop_front();
            checkOutput("write addr", 64'(address_bus), 64'(e.addr));
            checkOutput("write data", 64'(signed'(data_bus)), 64'(signed'(e.data)));
          end
        end
        lowRun = 0;
        armed  = 1'b1;
      end
      prevComplete = mem_sel && ready;
      prevSel      = mem_sel;
      prevAddr     = address_bus;
      prevW        = mem_w;
    end
  end

  task automatic loadCase(input int kind);
    for (int a = 0; a < 256; a++) mem[a] = 32'h5A5A_0000 | 32'(a);
    for (int n = 0; n < 4; n++) begin
      case (kind)
        0: begin
          mem[ACT_B + 8'(n)]     = {24'hABCDE1, 8'(n + 1)};
          mem[ACT_B + 8'(4 + n)] = {24'h000000, 8'(-(n + 1))};
        end
        1: begin
          mem[ACT_B + 8'(n)]     = {24'h123456, 8'h00};
          mem[ACT_B + 8'(4 + n)] = {24'hFFFFFF, 8'h00};
        end
        default: begin
          mem[ACT_B + 8'(n)]     = {24'h0F0F0F, 8'd127};
          mem[ACT_B + 8'(4 + n)] = {24'h0F0F0F, 8'd127};
        end
      endcase
      for (int i = 0; i < 3; i++) begin
        case (kind)
          0:       mem[WGT_B + 8'(i * 4 + n)] = {24'hFFFF00, 8'((i + 1) * (n + 1))};
          1:       mem[WGT_B + 8'(i * 4 + n)] = {24'h777777, 8'(i * 4 + n + 1)};
          2:       mem[WGT_B + 8'(i * 4 + n)] = {24'h000000, 8'd127};
          default: mem[WGT_B + 8'(i * 4 + n)] = {24'h000000, 8'h80};
        endcase
      end
    end
    case (kind)
      0: begin
        mem[BIAS_B] = 32'd10; mem[BIAS_B + 1] = 32'd20; mem[BIAS_B + 2] = 32'd30;
      end
      1: begin
        mem[BIAS_B] = 32'hFFFF_FFF9; mem[BIAS_B + 1] = 32'd5; mem[BIAS_B + 2] = 32'hFFFF_FFFF;
      end
      default: begin
        mem[BIAS_B] = 32'd0; mem[BIAS_B + 1] = 32'd0; mem[BIAS_B + 2] = 32'd0;
      end
    endcase
  endtask

  task automatic pushExp(input int v [6]);
    for (int i = 0; i < 6; i++) expQ.push_back('{addr: OUT_B + 8'(i), data: 32'(v[i])});
  endtask

  task automatic pulseStart(input bit r, input logic [4:0] s);
    @(posedge clk); #2;
    start = 1'b1; relu_en = r; shift = s;
    @(posedge clk); #2;
    start = 1'b0; relu_en = ~r; shift = ~s;
    activ_base = 8'h00; weight_base = 8'h01; bias_base = 8'h02; output_base = 8'h03;
  endtask

  task automatic restoreBases();
    activ_base = ACT_B; weight_base = WGT_B; bias_base = BIAS_B; output_base = OUT_B;
  endtask

  task automatic applyStimulus(input bit r, input logic [4:0] s, input bit spur,
                               input bit restart, input string tag);
    accessCount = 0; ovCount = 0; doneCount = 0; protoErr = 0; spurEn = spur;
    pulseStart(r, s);
    @(negedge clk);
    checkOutput({tag, " busy after start"}, 64'(busy), 64'd1);
    if (restart) begin
      repeat (30) @(posedge clk);
      #2; start = 1'b1; relu_en = 1'b1; shift = 5'd3;
      @(posedge clk); #2; start = 1'b0;
    end
    for (int c = 0; c < 3000 && doneCount == 0; c++) @(negedge clk);
    checkOutput({tag, " done seen"}, 64'(doneCount), 64'd1);
    repeat (5) @(negedge clk);
    checkOutput({tag, " done pulses"}, 64'(doneCount), 64'd1);
    checkOutput({tag, " out_valid pulses"}, 64'(ovCount), 64'd6);
    checkOutput({tag, " access count"}, 64'(accessCount), 64'd44);
    checkOutput({tag, " pending writes"}, 64'(expQ.size()), 64'd0);
    checkOutput({tag, " protocol errors"}, 64'(protoErr), 64'd0);
    checkOutput({tag, " busy idle"}, 64'(busy), 64'd0);
    spurEn = 1'b0;
    expQ.delete();
    restoreBases();
  endtask

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; shift = '0;
    restoreBases();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset mem_sel", 64'(mem_sel), 64'd0);
    checkOutput("reset mem_w", 64'(mem_w), 64'd0);
    checkOutput("reset address", 64'(address_bus), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset data_bus z", 64'(data_bus === 32'hzzzzzzzz), 64'd1);
    @(posedge clk); #2; rst = 1'b0;

    loadCase(0);
    pushExp('{40, 80, 120, -20, -40, -60});
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, "plain");

    loadCase(0);
    pushExp('{40, 80, 120, 0, 0, 0});
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, "relu+spurious");

    loadCase(0);
    pushExp('{10, 20, 30, -5, -10, -15});
    applyStimulus(1'b0, 5'd2, 1'b0, 1'b0, "shift2");

    loadCase(1);
    pushExp('{-4, 2, -1, -4, 2, -1});
    applyStimulus(1'b0, 5'd1, 1'b0, 1'b0, "bias shift1");

    loadCase(1);
    pushExp('{-1, 0, -1, -1, 0, -1});
    applyStimulus(1'b0, 5'd31, 1'b0, 1'b0, "bias shift31");

    loadCase(2);
    pushExp('{127, 127, 127, 127, 127, 127});
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, "sat pos");

    loadCase(3);
    pushExp('{-128, -128, -128, -128, -128, -128});
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, "sat neg");

    loadCase(0);
    pushExp('{40, 80, 120, -20, -40, -60});
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, "restart ignored");

    // Abort during the MAC of output 1: only the first write may appear
    loadCase(0);
    expQ.push_back('{addr: OUT_B, data: 32'd40});
    accessCount = 0; ovCount = 0; doneCount = 0; protoErr = 0;
    pulseStart(1'b0, 5'd0);
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (mem_sel && address_bus == WGT_B + 8'd4) found = 1'b1;
    end
    checkOutput("abort reached MAC m=1", 64'(found), 64'd1);
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    checkOutput("abort mem_sel", 64'(mem_sel), 64'd0);
    checkOutput("abort mem_w", 64'(mem_w), 64'd0);
    checkOutput("abort busy", 64'(busy), 64'd0);
    repeat (300) @(negedge clk);
    checkOutput("abort no done", 64'(doneCount), 64'd0);
    checkOutput("abort writes", 64'(expQ.size()), 64'd0);
    checkOutput("abort out_valid pulses", 64'(ovCount), 64'd1);
    expQ.delete();
    restoreBases();

    loadCase(0);
    pushExp('{40, 80, 120, -20, -40, -60});
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, "after abort");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
